prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_add.sv | 26 ++
 rtl/prog_counter.sv | 119 +++++++++++
 tb/tb_prog_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : pc_pkg                                                          |
// | Purpose : Shared definitions for the program counter block: the RUN/HALT  |
// |           state encoding and the default operand width and step.          |
// | Ports   : none (package)                                                  |
// | Config  : none                                                            |
// | Rev     : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package pc_pkg;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_e;

   localparam int C_DEFAULT_WIDTH = 6;
   localparam int C_DEFAULT_STEP  = 1;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pc_add                                                          |
// | Purpose : Unsigned WIDTH-bit adder with carry-out. This is the only       |
// |           arithmetic element on the PC path; both the sequential step     |
// |           and relative branches go through it.                            |
// | Ports   : a    [WIDTH-1:0] in  - first operand (current PC)               |
// |           b    [WIDTH-1:0] in  - second operand (step or branch offset)   |
// |           sum  [WIDTH-1:0] out - a + b modulo 2^WIDTH                      |
// |           cout             out - carry out of the top bit                 |
// | Config  : none                                                            |
// | Rev     : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module pc_add #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule : pc_add
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : prog_counter                                                    |
// | Purpose : Program counter with absolute load, relative branch, step       |
// |           advance and a RUN/HALT state machine. All outputs registered.   |
// | Ports   : clk                 in  - clock, rising edge                     |
// |           rst                 in  - synchronous active-high reset          |
// |           en                  in  - advance enable (RUN only)              |
// |           load                in  - absolute jump request                  |
// |           load_val [WIDTH-1:0] in - absolute jump target                   |
// |           br                  in  - relative branch request                |
// |           br_off   [WIDTH-1:0] in - two's-complement branch offset         |
// |           halt                in  - enter HALT (wins over resume)          |
// |           resume              in  - leave HALT                             |
// |           pc       [WIDTH-1:0] out - current program counter               |
// |           halted              out - high while in HALT                     |
// |           wrap                out - one-cycle pulse after a wrapping edge  |
// | Config  : PROG_COUNTER_WRAP_DETECT_EN - when defined, wrap reports modulo  |
// |           wrap-around; when undefined, wrap is held at 0.                  |
// | Rev     : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module prog_counter
   import pc_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH,
   parameter int STEP  = C_DEFAULT_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             br,
   input  logic [WIDTH-1:0] br_off,
   input  logic             halt,
   input  logic             resume,
   output logic [WIDTH-1:0] pc,
   output logic             halted,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

   pc_state_e        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;

   logic             w_advance;
   logic             w_take_br;
   logic [WIDTH-1:0] w_add_b;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_wrap_evt;

   // Load has priority over anything that uses the adder, so the adder
   // result is only committed when no load is pending.
   assign w_advance = (state_q == ST_RUN) && en && !load;
   assign w_take_br = w_advance && br;
   assign w_add_b   = w_take_br ? br_off : C_STEP;

   pc_add #(
      .WIDTH (WIDTH)
   ) u_add (
      .a    (pc_q),
      .b    (w_add_b),
      .sum  (w_sum),
      .cout (w_cout)
   );

`ifdef PROG_COUNTER_WRAP_DETECT_EN
   // Adding a negative offset in two's complement carries out whenever the
   // result stays at or above zero, so a backward wrap is the missing carry.
   assign w_wrap_evt = (w_take_br && br_off[WIDTH-1]) ? ~w_cout : w_cout;
`else
   logic w_unused_cout;
   assign w_unused_cout = w_cout;
   assign w_wrap_evt    = 1'b0;
`endif

   // State transitions: halt wins over resume; updates to the PC on the
   // same edge are independent of the state change.
   always_comb begin
      state_d = state_q;
      if (halt) begin
         state_d = ST_HALT;
      end else if ((state_q == ST_HALT) && resume) begin
         state_d = ST_RUN;
      end
   end

   always_comb begin
      pc_d   = pc_q;
      wrap_d = 1'b0;
      if (load) begin
         pc_d = load_val;
      end else if (w_advance) begin
         pc_d   = w_sum;
         wrap_d = w_wrap_evt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wrap_q  <= wrap_d;
      end
   end

   assign pc     = pc_q;
   assign halted = (state_q == ST_HALT);
   assign wrap   = wrap_q;

endmodule : prog_counter
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_prog_counter                                                 |
// | Purpose : Directed self-checking bench for prog_counter. Instance u0 is   |
// |           the default WIDTH=6/STEP=1 build; u1 is WIDTH=4/STEP=3.         |
// | Ports   : none                                                            |
// | Config  : PROG_COUNTER_WRAP_DETECT_EN selects expected wrap behaviour.    |
// | Rev     : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_prog_counter;

`ifdef PROG_COUNTER_WRAP_DETECT_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, en, load, br, halt, resume;
   logic [5:0] load_val, br_off;
   logic [5:0] pc;
   logic       halted, wrap;

   logic       en1, load1, br1, halt1, resume1;
   logic [3:0] load_val1, br_off1;
   logic [3:0] pc1;
   logic       halted1, wrap1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(6), .STEP(1)) u0 (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
      .br(br), .br_off(br_off), .halt(halt), .resume(resume),
      .pc(pc), .halted(halted), .wrap(wrap)
   );

   prog_counter #(.WIDTH(4), .STEP(3)) u1 (
      .clk(clk), .rst(rst), .en(en1), .load(load1), .load_val(load_val1),
      .br(br1), .br_off(br_off1), .halt(halt1), .resume(resume1),
      .pc(pc1), .halted(halted1), .wrap(wrap1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [5:0] e_pc, input logic e_halt, input logic e_wrap);
      chk({tag, ".pc"},     {26'd0, pc}, {26'd0, e_pc});
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
      chk({tag, ".wrap"},   {31'd0, wrap}, {31'd0, e_wrap});
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; br = 1'b0; halt = 1'b0; resume = 1'b0;
      load_val = '0; br_off = '0;
      en1 = 1'b0; load1 = 1'b0; br1 = 1'b0; halt1 = 1'b0; resume1 = 1'b0;
      load_val1 = '0; br_off1 = '0;

      // reset
      tick();
      chk3("reset", 6'd0, 1'b0, 1'b0);
      chk("reset.u1.pc", {28'd0, pc1}, 32'd0);

      // sequential advance 1..5
      rst = 1'b0; en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk3($sformatf("adv%0d", i), 6'(i), 1'b0, 1'b0);
      end

      // load 62 then advance across the top
      load = 1'b1; load_val = 6'd62;
      tick(); chk3("load62", 6'd62, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk3("adv63", 6'd63, 1'b0, 1'b0);
      tick(); chk3("adv_wrap0", 6'd0, 1'b0, WRAP_EN);
      tick(); chk3("adv_after_wrap", 6'd1, 1'b0, 1'b0);

      // backward branch without and with wrap
      load = 1'b1; load_val = 6'd10;
      tick(); chk3("load10", 6'd10, 1'b0, 1'b0);
      load = 1'b0; br = 1'b1; br_off = 6'b111100;
      tick(); chk3("br_back_nowrap", 6'd6, 1'b0, 1'b0);
      br = 1'b0; load = 1'b1; load_val = 6'd2;
      tick(); chk3("load2", 6'd2, 1'b0, 1'b0);
      load = 1'b0; br = 1'b1;
      tick(); chk3("br_back_wrap", 6'd62, 1'b0, WRAP_EN);

      // branch with en low is ignored
      en = 1'b0;
      tick(); chk3("br_en0_hold", 6'd62, 1'b0, 1'b0);
      br = 1'b0; en = 1'b1;

      // forward branch with and without wrap
      load = 1'b1; load_val = 6'd60;
      tick(); chk3("load60", 6'd60, 1'b0, 1'b0);
      load = 1'b0; br = 1'b1; br_off = 6'd5;
      tick(); chk3("br_fwd_wrap", 6'd1, 1'b0, WRAP_EN);
      br_off = 6'd3;
      tick(); chk3("br_fwd_nowrap", 6'd4, 1'b0, 1'b0);
      br = 1'b0;

      // halt sequence
      load = 1'b1; load_val = 6'd7;
      tick(); chk3("load7", 6'd7, 1'b0, 1'b0);
      load = 1'b0; halt = 1'b1;
      tick(); chk3("halt_enter", 6'd8, 1'b1, 1'b0);
      halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk3($sformatf("halt_hold%0d", i), 6'd8, 1'b1, 1'b0);
      end
      br = 1'b1; br_off = 6'd5;
      tick(); chk3("halt_br_ignored", 6'd8, 1'b1, 1'b0);
      br = 1'b0; load = 1'b1; load_val = 6'd20;
      tick(); chk3("halt_load20", 6'd20, 1'b1, 1'b0);
      load = 1'b0; resume = 1'b1;
      tick(); chk3("resume", 6'd20, 1'b0, 1'b0);
      resume = 1'b0;
      tick(); chk3("resume_adv", 6'd21, 1'b0, 1'b0);

      // halt and resume together: halt wins, advance still happens
      halt = 1'b1; resume = 1'b1;
      tick(); chk3("halt_resume_both", 6'd22, 1'b1, 1'b0);
      halt = 1'b0;
      tick(); chk3("resume2", 6'd22, 1'b0, 1'b0);
      resume = 1'b0;

      // load and branch together: load wins
      load = 1'b1; load_val = 6'd40; br = 1'b1; br_off = 6'd5;
      tick(); chk3("load_over_br", 6'd40, 1'b0, 1'b0);
      br = 1'b0;

      // reset overrides load and halt
      rst = 1'b1; load_val = 6'd33; halt = 1'b1;
      tick(); chk3("rst_over_load", 6'd0, 1'b0, 1'b0);
      rst = 1'b0; load = 1'b0;
      tick(); chk3("halt_again", 6'd1, 1'b1, 1'b0);
      halt = 1'b0; rst = 1'b1;
      tick(); chk3("rst_mid_halt", 6'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // WIDTH=4, STEP=3 instance
      load1 = 1'b1; load_val1 = 4'd14;
      tick(); chk("u1.load14.pc", {28'd0, pc1}, 32'd14);
      load1 = 1'b0; en1 = 1'b1;
      tick();
      chk("u1.adv_wrap.pc",   {28'd0, pc1}, 32'd1);
      chk("u1.adv_wrap.wrap", {31'd0, wrap1}, {31'd0, WRAP_EN});
      tick();
      chk("u1.adv.pc",   {28'd0, pc1}, 32'd4);
      chk("u1.adv.wrap", {31'd0, wrap1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_prog_counter
`default_nettype wire
